fpu_minmax_reduce16: RTL and testbench

Streaming min/max reduction stage that sits directly downstream of the fp16 comparator. It accepts a packet of fp16 values over a valid/ready stream and instantiates two fpuComp16 comparators: one for the running minimum, one for the running maximum. It tracks NaNs and an element count. On the last beat it presents one registered result. Typical consumers are normalisation and clamp-range logic.

---
 rtl/fpu_minmax_reduce16.sv | 130 +++++++++++++
 tb/tb_fpu_minmax_reduce16.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_minmax_reduce16.sv
// Streaming fp16 min/max reduction with NaN tracking and a saturating count.
// One registered result is presented per packet after its last beat.

module fpuComp16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        lt
);
   logic [15:0] ka;
   logic [15:0] kb;

   // Sign-magnitude to monotonic key; orders -0 below +0.
   assign ka = a[15] ? ~a : (a ^ 16'h8000);
   assign kb = b[15] ? ~b : (b ^ 16'h8000);
   assign lt = ka < kb;
endmodule

module fpu_minmax_reduce16 #(
   parameter int          COUNT_W = 16,
   parameter logic [15:0] QNAN    = 16'h7E00
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               inValid,
   output logic               inReady,
   input  logic [15:0]        inData,
   input  logic               inLast,
   output logic               outValid,
   input  logic               outReady,
   output logic [15:0]        outMin,
   output logic [15:0]        outMax,
   output logic [COUNT_W-1:0] outCount,
   output logic               outNaN
);
   typedef enum logic [1:0] {EMPTY, ACCUM, DONE} state_t;

   state_t             state_q, state_d;
   logic [15:0]        min_q, min_d;
   logic [15:0]        max_q, max_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               nan_q, nan_d;
   logic               have_q, have_d;
   logic               accept;
   logic               is_nan;
   logic               lt_min;
   logic               gt_max;

   assign accept = inValid && inReady;
   assign is_nan = (&inData[14:10]) && (|inData[9:0]);

   // Only registered extremes feed the comparators.
   fpuComp16 u_min (.a(inData), .b(min_q),  .lt(lt_min));
   fpuComp16 u_max (.a(max_q),  .b(inData), .lt(gt_max));

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      max_d   = max_q;
      count_d = count_q;
      nan_d   = nan_q;
      have_d  = have_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               if (is_nan) begin
                  nan_d = 1'b1;
               end else begin
                  min_d  = inData;
                  max_d  = inData;
                  have_d = 1'b1;
               end
               count_d = COUNT_W'(1);
               state_d = inLast ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               if (is_nan) begin
                  nan_d = 1'b1;
               end else if (!have_q) begin
                  min_d  = inData;
                  max_d  = inData;
                  have_d = 1'b1;
               end else begin
                  if (lt_min) min_d = inData;
                  if (gt_max) max_d = inData;
               end
               if (!(&count_q)) count_d = count_q + 1'b1;
               if (inLast) state_d = DONE;
            end
         end
         DONE: begin
            if (outReady) begin
               state_d = EMPTY;
               min_d   = QNAN;
               max_d   = QNAN;
               count_d = '0;
               nan_d   = 1'b0;
               have_d  = 1'b0;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         min_q   <= QNAN;
         max_q   <= QNAN;
         count_q <= '0;
         nan_q   <= 1'b0;
         have_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         max_q   <= max_d;
         count_q <= count_d;
         nan_q   <= nan_d;
         have_q  <= have_d;
      end
   end

   assign inReady  = (state_q != DONE);
   assign outValid = (state_q == DONE);
   assign outMin   = have_q ? min_q : QNAN;
   assign outMax   = have_q ? max_q : QNAN;
   assign outCount = count_q;
   assign outNaN   = nan_q;
endmodule

// File: tb/tb_fpu_minmax_reduce16.sv
// Scoreboard bench for fpu_minmax_reduce16: two instances (16-bit and 3-bit
// counters) share stimulus; results are checked against a real-valued model.

module tb_fpu_minmax_reduce16;
   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_last;
   logic        out_ready;

   logic        in_ready, out_valid, out_nan;
   logic [15:0] out_min, out_max, out_count;
   logic        in_ready3, out_valid3, out_nan3;
   logic [15:0] out_min3, out_max3;
   logic [2:0]  out_count3;

   always #5 clock = ~clock;

   fpu_minmax_reduce16 dut (
      .clock(clock), .reset_n(reset_n),
      .inValid(in_valid), .inReady(in_ready),
      .inData(in_data), .inLast(in_last),
      .outValid(out_valid), .outReady(out_ready),
      .outMin(out_min), .outMax(out_max),
      .outCount(out_count), .outNaN(out_nan)
   );

   fpu_minmax_reduce16 #(.COUNT_W(3)) dut3 (
      .clock(clock), .reset_n(reset_n),
      .inValid(in_valid), .inReady(in_ready3),
      .inData(in_data), .inLast(in_last),
      .outValid(out_valid3), .outReady(out_ready),
      .outMin(out_min3), .outMax(out_max3),
      .outCount(out_count3), .outNaN(out_nan3)
   );

   typedef struct {
      logic [15:0] mn;
      logic [15:0] mx;
      int          n;
      logic        nan;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] pkt[$];
   int          tests = 0;
   int          fails = 0;
   bit          rand_rdy = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic real fp_val(input logic [15:0] x);
      int  e;
      real m;
      e = int'(x[14:10]);
      if (e == 31) m = 1.0e10;
      else if (e == 0) m = real'(x[9:0]) * (2.0 ** (-24.0));
      else m = (1024.0 + real'(x[9:0])) * (2.0 ** real'(e - 25));
      return x[15] ? -m : m;
   endfunction

   function automatic bit nan16(input logic [15:0] x);
      return (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
   endfunction

   // a strictly below b; equal magnitudes only differ for the two zeros
   function automatic bit below(input logic [15:0] a, input logic [15:0] b);
      real va, vb;
      va = fp_val(a);
      vb = fp_val(b);
      return (va < vb) || (va == vb && a[15] && !b[15]);
   endfunction

   task automatic push_expect();
      exp_t e;
      bit   have;
      have  = 1'b0;
      e.mn  = 16'h7E00;
      e.mx  = 16'h7E00;
      e.nan = 1'b0;
      e.n   = pkt.size();
      foreach (pkt[i]) begin
         if (nan16(pkt[i])) begin
            e.nan = 1'b1;
         end else if (!have) begin
            have = 1'b1;
            e.mn = pkt[i];
            e.mx = pkt[i];
         end else begin
            if (below(pkt[i], e.mn)) e.mn = pkt[i];
            if (below(e.mx, pkt[i])) e.mx = pkt[i];
         end
      end
      sbq.push_back(e);
   endtask

   task automatic beat(input logic [15:0] d, input bit last);
      bit ok;
      bit took;
      took     = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int i = 0; i < 100; i++) begin
         ok = in_ready;
         @(posedge clock);
         #1;
         if (ok) begin
            took = 1'b1;
            break;
         end
      end
      if (!took) chk("beat_accept_timeout", 0, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_pkt(input int gap);
      push_expect();
      foreach (pkt[i]) begin
         beat(pkt[i], i == pkt.size() - 1);
         if (i != pkt.size() - 1) begin
            repeat ($urandom_range(0, gap)) begin
               @(posedge clock);
               #1;
            end
         end
      end
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 50 && !out_valid; i++) begin
         @(posedge clock);
         #1;
      end
      chk("wait_valid", out_valid, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sbq.size() != 0; i++) @(posedge clock);
      #1;
      chk("drain_empty", sbq.size(), 0);
   endtask

   task automatic chk_reset();
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_min", out_min, 16'h7E00);
      chk("rst_max", out_max, 16'h7E00);
      chk("rst_count", out_count, 0);
      chk("rst_nan", out_nan, 0);
      chk("rst_valid3", out_valid3, 0);
      chk("rst_count3", out_count3, 0);
      chk("rst_min3", out_min3, 16'h7E00);
   endtask

   function automatic logic [15:0] rand_fp();
      int k;
      k = $urandom_range(0, 11);
      if (k < 2) return {1'($urandom), 5'h1F, 10'($urandom_range(1, 1023))};
      if (k == 2) return {1'($urandom), 15'h7C00};
      if (k == 3) return {1'($urandom), 15'h0000};
      return {1'($urandom), 5'($urandom_range(0, 30)), 10'($urandom)};
   endfunction

   // Monitor: compares the head of the scoreboard whenever a result is shown
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset_n) begin
            chk("valid_pair", out_valid3, out_valid);
            if (out_valid) begin
               chk("ready_in_done", in_ready, 0);
               if (sbq.size() == 0) begin
                  chk("unexpected_result", 1, 0);
               end else begin
                  e = sbq[0];
                  chk("min", out_min, e.mn);
                  chk("max", out_max, e.mx);
                  chk("count", out_count, (e.n > 65535) ? 65535 : e.n);
                  chk("nan", out_nan, e.nan);
                  chk("min3", out_min3, e.mn);
                  chk("max3", out_max3, e.mx);
                  chk("count3", out_count3, (e.n > 7) ? 7 : e.n);
                  chk("nan3", out_nan3, e.nan);
                  if (out_ready) void'(sbq.pop_front());
               end
            end else begin
               chk("ready_idle", in_ready, 1);
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      #12;
      chk_reset();
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      pkt = '{16'h3C00, 16'hBC00, 16'h4000, 16'h3800};
      send_pkt(0);
      chk("latency_valid", out_valid, 1);
      @(posedge clock);
      #1;
      chk("turnaround_ready", in_ready, 1);
      chk("turnaround_valid", out_valid, 0);

      pkt = '{16'h0000, 16'h8000, 16'hFC00, 16'h7C00};
      send_pkt(0);
      pkt = '{16'h0000, 16'h8000};
      send_pkt(0);
      pkt = '{16'h7E01, 16'h3C00, 16'h7FFF};
      send_pkt(0);
      pkt = '{16'h7E01};
      send_pkt(0);
      pkt = {};
      for (int i = 0; i < 10; i++) pkt.push_back(16'h3C00 + 16'(i * 16'h100));
      send_pkt(0);
      drain();

      rand_rdy  = 1'b0;
      out_ready = 1'b0;
      pkt = '{16'h4400, 16'hC200, 16'h3555};
      send_pkt(3);
      wait_valid();
      repeat (5) begin
         @(posedge clock);
         #1;
      end
      chk("bp_hold_valid", out_valid, 1);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_ready", in_ready, 1);

      rand_rdy = 1'b1;
      for (int p = 0; p < 40; p++) begin
         pkt = {};
         for (int i = 0; i < $urandom_range(1, 12); i++) pkt.push_back(rand_fp());
         send_pkt(2);
      end
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      drain();

      beat(16'h3C00, 1'b0);
      beat(16'h4000, 1'b0);
      #3;
      reset_n = 1'b0;
      #1;
      chk_reset();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      pkt = '{16'h4000};
      send_pkt(0);
      drain();

      out_ready = 1'b0;
      pkt = '{16'hC000, 16'h4200};
      send_pkt(0);
      chk("done_valid", out_valid, 1);
      #3;
      reset_n = 1'b0;
      void'(sbq.pop_front());
      #1;
      chk_reset();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk("post_rst_valid", out_valid, 0);
      out_ready = 1'b1;
      pkt = '{16'h4000};
      send_pkt(0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
